// File: rtl/multicycle_cpu.sv
// Multicycle 16-bit-instruction CPU with four DATA_W-bit registers.
// Instruction and data memories use a req/ready handshake.
module multicycle_cpu #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              retire,
    output logic              halted
);
    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_mdr;
    logic [DATA_W-1:0] r_regs [4];

    logic [3:0]        w_op;
    logic [1:0]        w_rs;
    logic [1:0]        w_rt;
    logic [1:0]        w_rd;
    logic [1:0]        w_dst;
    logic              w_halt;
    logic              w_rtype;
    logic              w_addi;
    logic              w_lw;
    logic              w_sw;
    logic              w_beq;
    logic              w_bne;
    logic              w_taken;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_sub;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic [DATA_W-1:0] w_wb_val;
    logic [ADDR_W-1:0] w_boff;

    assign w_op    = r_ir[15:12];
    assign w_rs    = r_ir[11:10];
    assign w_rt    = r_ir[9:8];
    assign w_rd    = r_ir[7:6];
    assign w_halt  = (r_ir == 16'hFFFF);
    assign w_rtype = (w_op <= 4'h6);
    assign w_addi  = (w_op == 4'h7);
    assign w_lw    = (w_op == 4'h8);
    assign w_sw    = (w_op == 4'h9);
    assign w_beq   = (w_op == 4'hA);
    assign w_bne   = (w_op == 4'hB);
    assign w_taken = (w_beq && (r_a == r_b)) || (w_bne && (r_a != r_b));
    assign w_imm   = {{(DATA_W-8){r_ir[7]}}, r_ir[7:0]};
    assign w_boff  = {{(ADDR_W-9){r_ir[7]}}, r_ir[7:0], 1'b0};
    assign w_sub   = r_a - r_b;

    // r0 is never written, but force the read anyway so it is zero by construction
    assign w_rs_val = (w_rs == 2'd0) ? '0 : r_regs[w_rs];
    assign w_rt_val = (w_rt == 2'd0) ? '0 : r_regs[w_rt];
    assign w_dst    = (w_addi || w_lw) ? w_rt : w_rd;
    assign w_wb_val = w_lw ? r_mdr : r_alu;

    always_comb begin
        w_alu = r_a + w_imm;
        case (w_op)
            4'h0:    w_alu = r_a + r_b;
            4'h1:    w_alu = w_sub;
            4'h2:    w_alu = r_a & r_b;
            4'h3:    w_alu = r_a | r_b;
            4'h4:    w_alu = ~(r_a | r_b);
            4'h5:    w_alu = ~(r_a & r_b);
            4'h6:    w_alu = {{(DATA_W-1){1'b0}}, w_sub[DATA_W-1]};
            default: ;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        retire   = 1'b0;
        halted   = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req = !reset;
                if (imem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_halt) begin
                    w_next = S_HALT;
                    retire = 1'b1;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_rtype || w_addi) begin
                    w_next = S_WB;
                end else if (w_lw || w_sw) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_FETCH;
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = w_sw;
                if (dmem_ready) begin
                    w_next = w_lw ? S_WB : S_FETCH;
                    retire = w_sw;
                end
            end
            S_WB: begin
                retire = 1'b1;
                w_next = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_alu   <= '0;
            r_mdr   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        r_ir <= imem_rdata;
                        r_pc <= r_pc + ADDR_W'(2);
                    end
                end
                S_DECODE: begin
                    r_a <= w_rs_val;
                    r_b <= w_rt_val;
                end
                S_EXEC: begin
                    r_alu <= w_alu;
                    // pc already points past the branch
                    if (w_taken) r_pc <= r_pc + w_boff;
                end
                S_MEM: begin
                    if (dmem_ready && w_lw) r_mdr <= dmem_rdata;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r_regs[i] <= '0;
        end else if (r_state == S_WB && w_dst != 2'd0) begin
            r_regs[w_dst] <= w_wb_val;
        end
    end

    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign dmem_addr  = ADDR_W'(r_alu);
    assign dmem_wdata = r_b;
endmodule
